// File: rtl/audvid_clock_color_i2s_if.sv
// Pin bundle for audvid_clock_color_i2s: colour decode, divided clocks and the I2S transmitter.
// The Mute input exists only when AUDVID_MUTE_EN is defined.
interface audvid_clock_color_i2s_if;
    logic [3:0]  ColorIn;
    logic [15:0] ColorOut;
    logic [31:0] InputData;
    logic        TFTCLK;
    logic        SDCLK;
    logic        I2S_CLK;
    logic        I2S_DATA;
    logic        I2S_WS;
    logic        SyncCLK;
`ifdef AUDVID_MUTE_EN
    logic        Mute;

    modport slave (
        input  ColorIn, InputData, Mute,
        output ColorOut, TFTCLK, SDCLK, I2S_CLK, I2S_DATA, I2S_WS, SyncCLK
    );
    modport master (
        output ColorIn, InputData, Mute,
        input  ColorOut, TFTCLK, SDCLK, I2S_CLK, I2S_DATA, I2S_WS, SyncCLK
    );
`else
    modport slave (
        input  ColorIn, InputData,
        output ColorOut, TFTCLK, SDCLK, I2S_CLK, I2S_DATA, I2S_WS, SyncCLK
    );
    modport master (
        output ColorIn, InputData,
        input  ColorOut, TFTCLK, SDCLK, I2S_CLK, I2S_DATA, I2S_WS, SyncCLK
    );
`endif
endinterface

// File: rtl/audvid_clock_color_i2s.sv
// Clock dividers (TFT, SD, I2S), 4-bit colour to RGB565 decode, and a 32-bit Philips I2S transmitter.
// ColorOut is combinational; all other outputs are registered; no backpressure. Option macro: AUDVID_MUTE_EN.
module audvid_clock_color_i2s #(
    parameter int unsigned I2S_DIV = 38,
    parameter int unsigned TFT_DIV = 8,
    parameter int unsigned SD_DIV  = 4
) (
    input  logic                        CLK,
    input  logic                        Reset,
    audvid_clock_color_i2s_if.slave     av_if
);
    localparam int IW = $clog2(I2S_DIV + 1);
    localparam int TW = $clog2(TFT_DIV + 1);
    localparam int SW = $clog2(SD_DIV + 1);

    logic [IW-1:0] r_i2s_cnt;
    logic [TW-1:0] r_tft_cnt;
    logic [SW-1:0] r_sd_cnt;
    logic          r_i2s_clk;
    logic          r_tft_clk;
    logic          r_sd_clk;
    logic          w_i2s_wrap;
    logic          w_tft_wrap;
    logic          w_sd_wrap;

    assign w_i2s_wrap = (r_i2s_cnt == IW'(I2S_DIV - 1));
    assign w_tft_wrap = (r_tft_cnt == TW'(TFT_DIV - 1));
    assign w_sd_wrap  = (r_sd_cnt  == SW'(SD_DIV - 1));

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_i2s_cnt <= '0;
            r_i2s_clk <= 1'b0;
        end else if (w_i2s_wrap) begin
            r_i2s_cnt <= '0;
            r_i2s_clk <= ~r_i2s_clk;
        end else begin
            r_i2s_cnt <= r_i2s_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_tft_cnt <= '0;
            r_tft_clk <= 1'b0;
        end else if (w_tft_wrap) begin
            r_tft_cnt <= '0;
            r_tft_clk <= ~r_tft_clk;
        end else begin
            r_tft_cnt <= r_tft_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_sd_cnt <= '0;
            r_sd_clk <= 1'b0;
        end else if (w_sd_wrap) begin
            r_sd_cnt <= '0;
            r_sd_clk <= ~r_sd_clk;
        end else begin
            r_sd_cnt <= r_sd_cnt + 1'b1;
        end
    end

    // I2S frame: everything moves on the bit-clock falling edge so data is stable at the receiver's rising edge.
    logic        w_fall;
    logic [4:0]  w_bit_nxt;
    logic [31:0] w_sample;
    logic [4:0]  r_bitcnt;
    logic [31:0] r_shift;
    logic        r_ws;
    logic        r_sync;

    assign w_fall    = w_i2s_wrap & r_i2s_clk;
    assign w_bit_nxt = r_bitcnt + 5'd1;

`ifdef AUDVID_MUTE_EN
    assign w_sample = av_if.Mute ? 32'h0 : av_if.InputData;
`else
    assign w_sample = av_if.InputData;
`endif

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_bitcnt <= 5'd31;
            r_shift  <= '0;
            r_ws     <= 1'b0;
            r_sync   <= 1'b0;
        end else if (w_fall) begin
            r_bitcnt <= w_bit_nxt;
            r_shift  <= (w_bit_nxt == 5'd0) ? w_sample : {r_shift[30:0], 1'b0};
            r_ws     <= (w_bit_nxt >= 5'd15) && (w_bit_nxt <= 5'd30);
            r_sync   <= (w_bit_nxt == 5'd0);
        end
    end

    // Channel intensity: {on, I} selects 0, 1/3, 2/3 or full scale.
    function automatic logic [4:0] lvl5(input logic on, input logic hi);
        logic [4:0] v;
        case ({on, hi})
            2'b00:   v = 5'd0;
            2'b01:   v = 5'd10;
            2'b10:   v = 5'd21;
            default: v = 5'd31;
        endcase
        return v;
    endfunction

    function automatic logic [5:0] lvl6(input logic on, input logic hi);
        logic [5:0] v;
        case ({on, hi})
            2'b00:   v = 6'd0;
            2'b01:   v = 6'd21;
            2'b10:   v = 6'd42;
            default: v = 6'd63;
        endcase
        return v;
    endfunction

    assign av_if.ColorOut = {lvl5(av_if.ColorIn[2], av_if.ColorIn[3]),
                             lvl6(av_if.ColorIn[1], av_if.ColorIn[3]),
                             lvl5(av_if.ColorIn[0], av_if.ColorIn[3])};
    assign av_if.TFTCLK   = r_tft_clk;
    assign av_if.SDCLK    = r_sd_clk;
    assign av_if.I2S_CLK  = r_i2s_clk;
    assign av_if.I2S_DATA = r_shift[31];
    assign av_if.I2S_WS   = r_ws;
    assign av_if.SyncCLK  = r_sync;

endmodule

// File: tb/tb_audvid_clock_color_i2s.sv
// Bench for audvid_clock_color_i2s: a cycle-count model of clocks, I2S frames and colour decode.
// Build with AUDVID_MUTE_EN defined to exercise the Mute input as well.
module tb_audvid_clock_color_i2s;
    logic CLK   = 1'b0;
    logic Reset = 1'b0;

    audvid_clock_color_i2s_if bus();

    audvid_clock_color_i2s u_dut (
        .CLK   (CLK),
        .Reset (Reset),
        .av_if (bus)
    );

    always #5 CLK = ~CLK;

    int          errs   = 0;
    int          checks = 0;
    int          n      = 0;       // rising edges since reset release
    logic [31:0] cap    = '0;      // sample the model expects in flight
    logic [31:0] din    = '0;      // value currently driven on InputData
    logic        mute   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h (n=%0d)", tag, got, exp, n);
        end
    endtask

    function automatic logic [15:0] rgb(input logic [3:0] c);
        int lr, lg, lb, r, g, b;
        lr = (c[2] ? 2 : 0) + (c[3] ? 1 : 0);
        lg = (c[1] ? 2 : 0) + (c[3] ? 1 : 0);
        lb = (c[0] ? 2 : 0) + (c[3] ? 1 : 0);
        r  = (lr * 31 + 1) / 3;
        g  = (lg * 63 + 1) / 3;
        b  = (lb * 31 + 1) / 3;
        return 16'((r << 11) | (g << 5) | b);
    endfunction

    // Expected outputs purely from elapsed cycles: bit-clock falls every 76 cycles, 32 bits per frame.
    task automatic check_all();
        int   k, b;
        logic ws, sy, dt;
        k  = n / 76;
        b  = (k == 0) ? 31 : (k - 1) % 32;
        ws = (k > 0) && (b >= 15) && (b <= 30);
        sy = (k > 0) && (b == 0);
        dt = (k > 0) ? cap[31 - b] : 1'b0;
        check("tftclk",   bus.TFTCLK,   32'((n / 8) % 2));
        check("sdclk",    bus.SDCLK,    32'((n / 4) % 2));
        check("i2s_clk",  bus.I2S_CLK,  32'((n / 38) % 2));
        check("i2s_data", bus.I2S_DATA, dt);
        check("i2s_ws",   bus.I2S_WS,   ws);
        check("syncclk",  bus.SyncCLK,  sy);
        check("colorout", bus.ColorOut, rgb(bus.ColorIn));
    endtask

    task automatic step();
        @(posedge CLK);
        n++;
        if ((n % 76 == 0) && (((n / 76) - 1) % 32 == 0))
            cap = mute ? 32'h0 : din;
        #1;
        check_all();
    endtask

    initial begin
        logic [3:0] c;
        bus.ColorIn   = 4'h0;
        din           = 32'hA5A53C3C;
        bus.InputData = din;
`ifdef AUDVID_MUTE_EN
        bus.Mute      = 1'b0;
`endif
        #1;
        check_all();
        repeat (5) begin
            @(posedge CLK);
            #1;
            check_all();
        end

        for (int i = 0; i < 16; i++) begin
            c = 4'(i);
            bus.ColorIn = c;
            #1;
            check("color_sweep", bus.ColorOut, rgb(c));
        end
        bus.ColorIn = 4'h8; #1; check("color_8", bus.ColorOut, 32'h52AA);
        bus.ColorIn = 4'h4; #1; check("color_4", bus.ColorOut, 32'hA800);
        bus.ColorIn = 4'hF; #1; check("color_F", bus.ColorOut, 32'hFFFF);
        bus.ColorIn = 4'h0; #1; check("color_0", bus.ColorOut, 32'h0000);

        @(negedge CLK);
        Reset = 1'b1;
        n     = 0;

        // Frame 0 carries A5A53C3C, a mid-frame change lands in frame 1, later frames see random churn.
        while (n < 76 * (97 + 20) + 10) begin
            step();
            if (n == 76 * 11 + 5) din = 32'h12345678;
            if (n > 76 * 33 && $urandom_range(0, 49) == 0) din = $urandom;
            bus.InputData = din;
            bus.ColorIn   = 4'($urandom);
        end

`ifdef AUDVID_MUTE_EN
        mute     = 1'b1;
        bus.Mute = 1'b1;
`endif
        Reset = 1'b0;
        n     = 0;
        cap   = '0;
        #1;
        check_all();
        repeat (3) begin
            @(posedge CLK);
            #1;
            check_all();
        end
        Reset = 1'b1;

        while (n < 76 * 37) begin
            step();
            if ($urandom_range(0, 29) == 0) din = $urandom;
            bus.InputData = din;
            bus.ColorIn   = 4'($urandom);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/audvid_clock_color_i2s.md
AUDVID_CLOCK_COLOR_I2S -- requirements
Module: audvid_clock_color_i2s

Interface
REQ-001 SHALL have parameter I2S_DIV, default 38: I2S_CLK half-period in CLK cycles (1.316 MHz at 100 MHz, 32 bits/frame, ~41.1 kHz fs).
REQ-002 SHALL have parameter TFT_DIV, default 8: TFTCLK half-period in CLK cycles (6.25 MHz).
REQ-003 SHALL have parameter SD_DIV, default 4: SDCLK half-period in CLK cycles (12.5 MHz).
REQ-004 SHALL have port CLK  in  1  the single 100 MHz system clock; all logic on posedge CLK.
REQ-005 SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port ColorIn  in  4  encoded pixel colour.
REQ-007 SHALL have port ColorOut  out  16  RGB565 pixel.
REQ-008 SHALL have port InputData  in  32  stereo sample; [31:16] left, [15:0] right, two's complement.
REQ-009 SHALL have port TFTCLK  out  1  divided square wave, 50% duty.
REQ-010 SHALL have port SDCLK  out  1  divided square wave, 50% duty.
REQ-011 SHALL have ports I2S_CLK, I2S_DATA, I2S_WS  out  1 each  Philips I2S bit clock, serial data, word select.
REQ-012 SHALL have port SyncCLK  out  1  frame strobe; sample consumers use its rising edge.

Function
REQ-013 Each divider SHALL be a counter 0..DIV-1 toggling its output on the wrap cycle; all outputs registered, glitch-free.
REQ-014 ColorOut SHALL be combinational: I=ColorIn[3], R=[2], G=[1], B=[0].
REQ-015 Each channel SHALL map: off,I=0 -> 0; off,I=1 -> 1/3; on,I=0 -> 2/3; on,I=1 -> full. Values: R5/B5 = 0,10,21,31; G6 = 0,21,42,63.
REQ-016 Decode examples: 0x0->0x0000, 0x8->0x52AA, 0x4->0xA800, 0xF->0xFFFF.
REQ-017 Bit counter bitcnt (5 bits) SHALL advance on each I2S_CLK falling-edge event (CLK cycle where I2S_CLK goes 1->0), wrapping 31->0.
REQ-018 On the falling-edge event entering bitcnt=0, InputData SHALL be captured into the shift register; I2S_DATA SHALL equal captured[31-bitcnt] for the whole bit period.
REQ-019 I2S_WS SHALL be 1 exactly while bitcnt is 15..30 and 0 otherwise (one-bit lead before each channel MSB; left when WS=0).
REQ-020 I2S_DATA and I2S_WS SHALL change only on the CLK cycle I2S_CLK falls; stable across the rising edge.
REQ-021 SyncCLK SHALL be 1 exactly while bitcnt=0 (one bit period), rising on the capture cycle.
REQ-022 InputData changes outside the capture cycle SHALL not affect the frame in flight.
REQ-023 First frame after reset SHALL shift the sample captured at the first falling-edge event (bitcnt 31->0).

Reset
REQ-024 Reset low SHALL immediately force all counters 0, TFTCLK=SDCLK=I2S_CLK=0, I2S_DATA=0, I2S_WS=0, SyncCLK=0, shift register 0, bitcnt=31.
REQ-025 Reset mid-frame SHALL abandon the frame; after release, first I2S_CLK rise after I2S_DIV cycles, frame restarts at bitcnt 0.
REQ-026 ColorOut SHALL be unaffected by Reset.

Configuration
REQ-027 With AUDVID_MUTE_EN defined, SHALL add input Mute (1 bit); Mute=1 at capture loads 0x00000000; I2S timing unchanged.
REQ-028 Without AUDVID_MUTE_EN, no Mute port exists; InputData always captured.

Verification
REQ-029 Reset low 5 cycles, release -> all outputs 0; I2S_CLK first rises at cycle 38, period 76 cycles.
REQ-030 Free run 1000 cycles -> TFTCLK period 16, SDCLK period 8, both 50% duty.
REQ-031 Sweep ColorIn 0..15 -> 0x0000, 0x5400-class per REQ-015, incl. 0x8->0x52AA, 0xF->0xFFFF.
REQ-032 InputData=0xA5A53C3C -> I2S_DATA bits 1010010110100101 then 0011110000111100, WS 0 then 1 with one-bit lead, SyncCLK high during first bit only.
REQ-033 Change InputData to 0x12345678 at bitcnt 10 -> current frame still 0xA5A53C3C; next frame 0x12345678.
REQ-034 Assert Reset at bitcnt 20, Mute=1 (AUDVID_MUTE_EN) -> outputs 0 at once; after release frames are all-zero with correct WS.
